// File: rtl/serial_result_collector_pkg.sv
// Shared types and sizing helpers for the b01 comparator result path.
// Holds the collector state encoding and default frame/counter widths.
package b01_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } collector_state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;

  // Ceiling log2; the bit counter only needs to reach WIDTH-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_result_collector_hold.sv
// result_hold_reg: one-deep valid/ready word buffer; output is the register, 1-cycle load latency.
// Backpressure: accepts a load only when empty or draining this cycle (load_ok_o); else caller drops.
module result_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ovf_i,
`ifdef COLLECTOR_PARITY_EN
  input  logic             par_i,
  output logic             par_o,
`endif
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             ovf_o,
  output logic             load_ok_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ovf_q, ovf_d;
`ifdef COLLECTOR_PARITY_EN
  logic             par_q, par_d;
`endif

  assign load_ok_o = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
`ifdef COLLECTOR_PARITY_EN
    par_d   = par_q;
`endif
    if (valid_q && ready_i) valid_d = 1'b0;
    // A load in the same cycle as a drain replaces the word and keeps valid high.
    if (load_i && load_ok_o) begin
      valid_d = 1'b1;
      data_d  = data_i;
      ovf_d   = ovf_i;
`ifdef COLLECTOR_PARITY_EN
      par_d   = par_i;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef COLLECTOR_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
`ifdef COLLECTOR_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ovf_o   = ovf_q;
`ifdef COLLECTOR_PARITY_EN
  assign par_o   = par_q;
`endif

endmodule

// File: rtl/serial_result_collector.sv
// Collects LSB-first serial comparator bits into WIDTH-bit frames; word valid the edge after the last bit.
// Backpressure: one-deep hold reg, frames completing while it is full are dropped and counted; COLLECTOR_PARITY_EN adds res_par.
module serial_result_collector
  import b01_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             frame_start,
  input  logic             outp,
  input  logic             overflw,
  output logic [WIDTH-1:0] res_data,
  output logic             res_ovf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] drop_cnt,
`ifdef COLLECTOR_PARITY_EN
  output logic             res_par,
`endif
  output logic             busy
);

  localparam int BW = clog2(WIDTH);

  collector_state_t state_q, state_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [WIDTH-1:0] frame_word;
  logic             frame_ovf;
  logic             complete;
  logic             abort;
  logic             load_ok;

  always_comb begin
    state_d              = state_q;
    bit_cnt_d            = bit_cnt_q;
    shift_d              = shift_q;
    ovf_d                = ovf_q;
    complete             = 1'b0;
    abort                = 1'b0;
    frame_word           = shift_q;
    frame_word[bit_cnt_q] = outp;
    frame_ovf            = ovf_q | overflw;

    unique case (state_q)
      IDLE: begin
        if (in_valid && frame_start) begin
          shift_d   = {{(WIDTH-1){1'b0}}, outp};
          ovf_d     = overflw;
          bit_cnt_d = BW'(1);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (in_valid) begin
          if (frame_start) begin
            // Restart on the current bit; the partial frame is lost.
            abort     = 1'b1;
            shift_d   = {{(WIDTH-1){1'b0}}, outp};
            ovf_d     = overflw;
            bit_cnt_d = BW'(1);
          end else if (bit_cnt_q == BW'(WIDTH - 1)) begin
            complete  = 1'b1;
            shift_d   = '0;
            ovf_d     = 1'b0;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            shift_d   = frame_word;
            ovf_d     = frame_ovf;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    drop_d = drop_q;
    if ((abort || (complete && !load_ok)) && (drop_q != {CNT_W{1'b1}})) begin
      drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ovf_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
    end
  end

  result_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clock     (clock),
    .reset     (reset),
    .load_i    (complete),
    .data_i    (frame_word),
    .ovf_i     (frame_ovf),
`ifdef COLLECTOR_PARITY_EN
    .par_i     (^frame_word),
    .par_o     (res_par),
`endif
    .ready_i   (res_ready),
    .valid_o   (res_valid),
    .data_o    (res_data),
    .ovf_o     (res_ovf),
    .load_ok_o (load_ok)
  );

  assign drop_cnt = drop_q;
  assign busy     = (state_q == SHIFT);

endmodule

// File: tb/tb_serial_result_collector.sv
// Self-checking bench for serial_result_collector: vector table, directed corner sequences, random vs. model.
module tb_serial_result_collector;

  localparam int W     = 8;
  localparam int CNT_W = 4;

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic             frame_start;
  logic             outp;
  logic             overflw;
  logic [W-1:0]     res_data;
  logic             res_ovf;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] drop_cnt;
  logic             busy;
`ifdef COLLECTOR_PARITY_EN
  logic             res_par;
`endif

  int checks   = 0;
  int failures = 0;

  serial_result_collector #(.WIDTH(W), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .frame_start (frame_start),
    .outp        (outp),
    .overflw     (overflw),
    .res_data    (res_data),
    .res_ovf     (res_ovf),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .drop_cnt    (drop_cnt),
`ifdef COLLECTOR_PARITY_EN
    .res_par     (res_par),
`endif
    .busy        (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [0:7] seq;
    logic [0:7] ovf;
    logic [7:0] exp_data;
    logic       exp_ovf;
    logic       exp_par;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read at the same point.
  task automatic step(input logic v, input logic fs, input logic o, input logic ov, input logic rdy);
    in_valid    = v;
    frame_start = fs;
    outp        = o;
    overflw     = ov;
    res_ready   = rdy;
    @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [0:7] seq, input logic [0:7] ovf, input logic rdy);
    for (int i = 0; i < 8; i++) step(1'b1, i == 0, seq[i], ovf[i], rdy);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 0; frame_start = 0; outp = 0; overflw = 0; res_ready = 0;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // Reference model state
  bit       m_in_frame;
  int       m_pos;
  int       m_cur;
  bit       m_cov;
  bit       m_valid;
  int       m_data;
  bit       m_ovf;
  int       m_drop;

  task automatic model_step(input bit v, input bit fs, input bit o, input bit ov, input bit rdy);
    bit fire, done, lost;
    fire = m_valid && rdy;
    done = 0;
    lost = 0;
    if (v) begin
      if (fs) begin
        if (m_in_frame) lost = 1;
        m_in_frame = 1;
        m_pos = 1;
        m_cur = int'(o);
        m_cov = ov;
      end else if (m_in_frame) begin
        m_cur = m_cur + (int'(o) * (1 << m_pos));
        m_cov = m_cov | ov;
        m_pos++;
        if (m_pos == W) begin
          done = 1;
          m_in_frame = 0;
        end
      end
    end
    if (fire) m_valid = 0;
    if (done) begin
      if (!m_valid) begin
        m_valid = 1;
        m_data  = m_cur;
        m_ovf   = m_cov;
      end else begin
        lost = 1;
      end
    end
    if (lost && m_drop < (1 << CNT_W) - 1) m_drop++;
  endtask

  initial begin
    vecs[0] = '{8'b10110010, 8'b00000000, 8'h4D, 1'b0, 1'b0};
    vecs[1] = '{8'b10110010, 8'b00000100, 8'h4D, 1'b1, 1'b0};
    vecs[2] = '{8'b00110010, 8'b00000000, 8'h4C, 1'b0, 1'b1};
    vecs[3] = '{8'b11111111, 8'b10000000, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'b00000001, 8'b00000001, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'b10000000, 8'b00000000, 8'h01, 1'b0, 1'b1};

    // Reset state
    reset = 1'b0;
    in_valid = 0; frame_start = 0; outp = 0; overflw = 0; res_ready = 0;
    #2;
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_data",  32'(res_data), 0);
    chk("rst_drop",  32'(drop_cnt), 0);
    chk("rst_busy",  32'(busy), 0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Table of back-to-back frames with the consumer always ready
    for (int k = 0; k < 6; k++) begin
      send_frame(vecs[k].seq, vecs[k].ovf, 1'b1);
      chk("tbl_valid", 32'(res_valid), 1);
      chk("tbl_data",  32'(res_data), 32'(vecs[k].exp_data));
      chk("tbl_ovf",   32'(res_ovf), 32'(vecs[k].exp_ovf));
      chk("tbl_busy",  32'(busy), 0);
      chk("tbl_drop",  32'(drop_cnt), 0);
`ifdef COLLECTOR_PARITY_EN
      chk("tbl_par",   32'(res_par), 32'(vecs[k].exp_par));
`endif
    end
    step(0, 0, 0, 0, 1);
    chk("drain_valid", 32'(res_valid), 0);

    // Stall mid-frame
    do_reset();
    for (int i = 0; i < 4; i++) step(1, i == 0, vecs[1].seq[i], vecs[1].ovf[i], 1);
    for (int s = 0; s < 3; s++) begin
      step(0, 0, 1, 1, 1);
      chk("stall_busy",  32'(busy), 1);
      chk("stall_valid", 32'(res_valid), 0);
    end
    for (int i = 4; i < 8; i++) step(1, 0, vecs[1].seq[i], vecs[1].ovf[i], 1);
    chk("stall_data", 32'(res_data), 32'h4D);
    chk("stall_ovf",  32'(res_ovf), 1);
    chk("stall_vld",  32'(res_valid), 1);

    // Backpressure: second frame dropped, first word held then delivered
    do_reset();
    send_frame(8'b10110010, 8'h00, 0);
    send_frame(8'b00110010, 8'h00, 0);
    chk("bp_valid", 32'(res_valid), 1);
    chk("bp_data",  32'(res_data), 32'h4D);
    chk("bp_drop",  32'(drop_cnt), 1);
    step(0, 0, 0, 0, 1);
    chk("bp_drained", 32'(res_valid), 0);

    // Drain and load on the same edge
    do_reset();
    send_frame(8'b10110010, 8'h00, 0);
    for (int i = 0; i < 7; i++) step(1, i == 0, vecs[2].seq[i], 0, 0);
    step(1, 0, vecs[2].seq[7], 0, 1);
    chk("dl_valid", 32'(res_valid), 1);
    chk("dl_data",  32'(res_data), 32'h4C);
    chk("dl_drop",  32'(drop_cnt), 0);

    // Abort at bit 4, then new frame completes
    do_reset();
    for (int i = 0; i < 4; i++) step(1, i == 0, 1, 0, 1);
    step(1, 1, vecs[2].seq[0], 0, 1);
    chk("ab_drop", 32'(drop_cnt), 1);
    chk("ab_busy", 32'(busy), 1);
    for (int i = 1; i < 8; i++) step(1, 0, vecs[2].seq[i], 0, 1);
    chk("ab_valid", 32'(res_valid), 1);
    chk("ab_data",  32'(res_data), 32'h4C);
    chk("ab_ovf",   32'(res_ovf), 0);

    // Drop counter saturation
    do_reset();
    step(1, 1, 0, 0, 1);
    for (int i = 0; i < 14; i++) step(1, 1, 0, 0, 1);
    chk("sat_14", 32'(drop_cnt), 14);
    step(1, 1, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    chk("sat_15", 32'(drop_cnt), 15);

    // Asynchronous reset mid-frame with a word held
    do_reset();
    send_frame(8'b10110010, 8'h04, 0);
    for (int i = 0; i < 3; i++) step(1, i == 0, 1, 0, 0);
    chk("pre_rst_busy", 32'(busy), 1);
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(res_valid), 0);
    chk("arst_data",  32'(res_data), 0);
    chk("arst_ovf",   32'(res_ovf), 0);
    chk("arst_busy",  32'(busy), 0);
    chk("arst_drop",  32'(drop_cnt), 0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Random traffic against the reference model
    do_reset();
    m_in_frame = 0; m_pos = 0; m_cur = 0; m_cov = 0;
    m_valid = 0; m_data = 0; m_ovf = 0; m_drop = 0;
    for (int c = 0; c < 3000; c++) begin
      bit v, fs, o, ov, rdy;
      v   = ($urandom_range(0, 9) < 7);
      fs  = ($urandom_range(0, 19) == 0);
      o   = $urandom_range(0, 1);
      ov  = ($urandom_range(0, 15) == 0);
      rdy = $urandom_range(0, 1);
      model_step(v, fs, o, ov, rdy);
      step(v, fs, o, ov, rdy);
      chk("rnd_valid", 32'(res_valid), 32'(m_valid));
      chk("rnd_busy",  32'(busy), 32'(m_in_frame));
      chk("rnd_drop",  32'(drop_cnt), 32'(m_drop));
      if (m_valid) begin
        chk("rnd_data", 32'(res_data), 32'(m_data));
        chk("rnd_ovf",  32'(res_ovf), 32'(m_ovf));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
